// File: rtl/cpu_flag.sv
// cpu_flag: flag register and condition unit for the 8008 core.
//
// Holds the C/Z/S/P flags loaded from the ALU. It also executes the four
// accumulator rotates (RLC/RRC/RAL/RAR), which read and write carry, and
// evaluates the jump/call/return condition field against the stored flags.
// Rotate and condition requests come from the sequencer as one-cycle pulses.
// Each accepted request runs IDLE -> ROT|EVAL -> DONE -> IDLE.
//
// Ports:
//   CLK_I, RST_N_I            clock, async active-low reset
//   ALU_{C,Z,S,P}_I           ALU flag outputs
//   ALU_UPD_I / INR_UPD_I     load all flags / load Z,S,P only
//   ROT_I, ROT_OP_I, ACC_I    rotate request, opcode, operand
//   COND_REQ_I, COND_I        condition request, {T, CC[1:0]}
//   ACC_O, ACC_VLD_O          registered rotate result + valid pulse
//   COND_TRUE_O, COND_VLD_O   registered condition result + valid pulse
//   C_O, Z_O, S_O, P_O        flag register
//   BUSY_O                    an operation is in flight
module cpu_flag (
    input  logic       CLK_I,
    input  logic       RST_N_I,
    input  logic       ALU_C_I,
    input  logic       ALU_Z_I,
    input  logic       ALU_S_I,
    input  logic       ALU_P_I,
    input  logic       ALU_UPD_I,
    input  logic       INR_UPD_I,
    input  logic       ROT_I,
    input  logic [1:0] ROT_OP_I,
    input  logic [7:0] ACC_I,
    input  logic       COND_REQ_I,
    input  logic [2:0] COND_I,
    output logic [7:0] ACC_O,
    output logic       ACC_VLD_O,
    output logic       COND_TRUE_O,
    output logic       COND_VLD_O,
    output logic       C_O,
    output logic       Z_O,
    output logic       S_O,
    output logic       P_O,
    output logic       BUSY_O
);

    typedef enum logic [1:0] {IDLE, ROT, EVAL, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] opnd_q, opnd_d;
    logic [1:0] op_q, op_d;
    logic [2:0] cond_q, cond_d;
    logic [7:0] acc_q, acc_d;
    logic       acc_vld_q, acc_vld_d;
    logic       cond_true_q, cond_true_d;
    logic       cond_vld_q, cond_vld_d;
    logic       c_q, c_d, z_q, z_d, s_q, s_d, p_q, p_d;

    logic [7:0] rot_res;
    logic       rot_c;
    logic       sel_flag;

    // Rotate datapath; RAL/RAR shift the stored carry in.
    always_comb begin
        rot_res = opnd_q;
        rot_c   = c_q;
        case (op_q)
            2'b00: begin rot_res = {opnd_q[6:0], opnd_q[7]}; rot_c = opnd_q[7]; end
            2'b01: begin rot_res = {opnd_q[0], opnd_q[7:1]}; rot_c = opnd_q[0]; end
            2'b10: begin rot_res = {opnd_q[6:0], c_q};       rot_c = opnd_q[7]; end
            default: begin rot_res = {c_q, opnd_q[7:1]};     rot_c = opnd_q[0]; end
        endcase
    end

    always_comb begin
        case (cond_q[1:0])
            2'b00:   sel_flag = c_q;
            2'b01:   sel_flag = z_q;
            2'b10:   sel_flag = s_q;
            default: sel_flag = p_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        opnd_d      = opnd_q;
        op_d        = op_q;
        cond_d      = cond_q;
        acc_d       = acc_q;
        acc_vld_d   = 1'b0;
        cond_true_d = cond_true_q;
        cond_vld_d  = 1'b0;
        c_d         = c_q;
        z_d         = z_q;
        s_d         = s_q;
        p_d         = p_q;

        // Flag loads are accepted in any state; a full ALU load beats INr/DCr.
        if (ALU_UPD_I) begin
            c_d = ALU_C_I;
            z_d = ALU_Z_I;
            s_d = ALU_S_I;
            p_d = ALU_P_I;
        end else if (INR_UPD_I) begin
            z_d = ALU_Z_I;
            s_d = ALU_S_I;
            p_d = ALU_P_I;
        end

        case (state_q)
            IDLE: begin
                if (ROT_I) begin
                    opnd_d  = ACC_I;
                    op_d    = ROT_OP_I;
                    state_d = ROT;
                end else if (COND_REQ_I) begin
                    cond_d  = COND_I;
                    state_d = EVAL;
                end
            end
            ROT: begin
                acc_d     = rot_res;
                c_d       = rot_c;      // rotate carry overrides any ALU carry
                acc_vld_d = 1'b1;
                state_d   = DONE;
            end
            EVAL: begin
                cond_true_d = (sel_flag == cond_q[2]);
                cond_vld_d  = 1'b1;
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q     <= IDLE;
            opnd_q      <= 8'h00;
            op_q        <= 2'b00;
            cond_q      <= 3'b000;
            acc_q       <= 8'h00;
            acc_vld_q   <= 1'b0;
            cond_true_q <= 1'b0;
            cond_vld_q  <= 1'b0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            s_q         <= 1'b0;
            p_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            opnd_q      <= opnd_d;
            op_q        <= op_d;
            cond_q      <= cond_d;
            acc_q       <= acc_d;
            acc_vld_q   <= acc_vld_d;
            cond_true_q <= cond_true_d;
            cond_vld_q  <= cond_vld_d;
            c_q         <= c_d;
            z_q         <= z_d;
            s_q         <= s_d;
            p_q         <= p_d;
        end
    end

    assign ACC_O       = acc_q;
    assign ACC_VLD_O   = acc_vld_q;
    assign COND_TRUE_O = cond_true_q;
    assign COND_VLD_O  = cond_vld_q;
    assign C_O         = c_q;
    assign Z_O         = z_q;
    assign S_O         = s_q;
    assign P_O         = p_q;
    assign BUSY_O      = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_flag.sv
module tb_cpu_flag;

    logic       CLK_I = 1'b0;
    logic       RST_N_I = 1'b0;
    logic       ALU_C_I = 1'b0, ALU_Z_I = 1'b0, ALU_S_I = 1'b0, ALU_P_I = 1'b0;
    logic       ALU_UPD_I = 1'b0, INR_UPD_I = 1'b0;
    logic       ROT_I = 1'b0;
    logic [1:0] ROT_OP_I = 2'b00;
    logic [7:0] ACC_I = 8'h00;
    logic       COND_REQ_I = 1'b0;
    logic [2:0] COND_I = 3'b000;
    logic [7:0] ACC_O;
    logic       ACC_VLD_O, COND_TRUE_O, COND_VLD_O;
    logic       C_O, Z_O, S_O, P_O, BUSY_O;

    int errors = 0;
    int checks = 0;

    // Reference model state: flags indexed by CC (0=C,1=Z,2=S,3=P).
    int         mflag [4];
    logic [7:0] macc;
    logic       mtrue;

    cpu_flag dut (
        .CLK_I(CLK_I), .RST_N_I(RST_N_I),
        .ALU_C_I(ALU_C_I), .ALU_Z_I(ALU_Z_I), .ALU_S_I(ALU_S_I), .ALU_P_I(ALU_P_I),
        .ALU_UPD_I(ALU_UPD_I), .INR_UPD_I(INR_UPD_I),
        .ROT_I(ROT_I), .ROT_OP_I(ROT_OP_I), .ACC_I(ACC_I),
        .COND_REQ_I(COND_REQ_I), .COND_I(COND_I),
        .ACC_O(ACC_O), .ACC_VLD_O(ACC_VLD_O),
        .COND_TRUE_O(COND_TRUE_O), .COND_VLD_O(COND_VLD_O),
        .C_O(C_O), .Z_O(Z_O), .S_O(S_O), .P_O(P_O), .BUSY_O(BUSY_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    // Rotate semantics as byte arithmetic.
    function automatic void model_rot(input int op, input int a, input int c,
                                      output int res, output int nc);
        case (op)
            0: begin res = (a * 2) % 256 + a / 128;   nc = a / 128; end
            1: begin res = a / 2 + (a % 2) * 128;     nc = a % 2;   end
            2: begin res = (a * 2) % 256 + c;         nc = a / 128; end
            default: begin res = a / 2 + c * 128;     nc = a % 2;   end
        endcase
    endfunction

    function automatic logic [3:0] mflags();
        return {mflag[0][0], mflag[1][0], mflag[2][0], mflag[3][0]};
    endfunction

    task automatic alu_load(input int c, input int z, input int s, input int p);
        ALU_C_I = c[0]; ALU_Z_I = z[0]; ALU_S_I = s[0]; ALU_P_I = p[0];
        ALU_UPD_I = 1'b1;
        tick();
        ALU_UPD_I = 1'b0;
        mflag[0] = c; mflag[1] = z; mflag[2] = s; mflag[3] = p;
    endtask

    // Drives a rotate request; returns in the cycle the result should be valid.
    task automatic issue_rot(input int op, input int a, output logic busy1, output logic vld1);
        ROT_OP_I = op[1:0]; ACC_I = a[7:0]; ROT_I = 1'b1;
        tick();
        ROT_I = 1'b0;
        busy1 = BUSY_O; vld1 = ACC_VLD_O | COND_VLD_O;
        tick();
    endtask

    task automatic issue_cond(input logic [2:0] cnd, output logic busy1, output logic vld1);
        COND_I = cnd; COND_REQ_I = 1'b1;
        tick();
        COND_REQ_I = 1'b0;
        busy1 = BUSY_O; vld1 = ACC_VLD_O | COND_VLD_O;
        tick();
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        logic        saw_vld;
        RST_N_I = 1'b0;
        #12;
        obs = {ACC_O, ACC_VLD_O, COND_TRUE_O, COND_VLD_O, C_O, Z_O, S_O, P_O, BUSY_O};
        checks++;
        if (obs !== 15'h0) begin errors++; $display("FAIL reset_state: got %h want 0000", obs); end
        @(negedge CLK_I); RST_N_I = 1'b1;
        tick();
        obs = {ACC_O, ACC_VLD_O, COND_TRUE_O, COND_VLD_O, C_O, Z_O, S_O, P_O, BUSY_O};
        checks++;
        if (obs !== 15'h0) begin errors++; $display("FAIL post_reset_idle: got %h want 0000", obs); end
        // RLC 0x80 would set carry; reset in the ROT cycle must abort it.
        ROT_OP_I = 2'b00; ACC_I = 8'h80; ROT_I = 1'b1;
        tick();
        ROT_I = 1'b0;
        checks++;
        if (BUSY_O !== 1'b1) begin errors++; $display("FAIL rot_busy_before_abort: got %b want 1", BUSY_O); end
        #2 RST_N_I = 1'b0;
        #1;
        checks++;
        if (BUSY_O !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", BUSY_O); end
        @(negedge CLK_I); RST_N_I = 1'b1;
        saw_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_vld |= ACC_VLD_O;
        end
        checks++;
        if (saw_vld !== 1'b0) begin errors++; $display("FAIL abort_no_vld: got %b want 0", saw_vld); end
        checks++;
        if ({C_O, ACC_O} !== 9'h0) begin errors++; $display("FAIL abort_no_write: got C=%b ACC=%h want C=0 ACC=00", C_O, ACC_O); end
        for (int i = 0; i < 4; i++) mflag[i] = 0;
        macc = 8'h00; mtrue = 1'b0;
    endtask

    task automatic test_flag_load();
        alu_load(1, 0, 1, 1);
        checks++;
        if ({C_O, Z_O, S_O, P_O} !== 4'b1011) begin errors++; $display("FAIL alu_load: got %b want 1011", {C_O, Z_O, S_O, P_O}); end
        ALU_C_I = 1'b0; ALU_Z_I = 1'b0; ALU_S_I = 1'b0; ALU_P_I = 1'b0;
        INR_UPD_I = 1'b1;
        tick();
        INR_UPD_I = 1'b0;
        mflag[1] = 0; mflag[2] = 0; mflag[3] = 0;
        checks++;
        if ({C_O, Z_O, S_O, P_O} !== 4'b1000) begin errors++; $display("FAIL inr_load: got %b want 1000", {C_O, Z_O, S_O, P_O}); end
        // Both loads together: full ALU load wins, so C follows ALU_C_I.
        ALU_C_I = 1'b0; ALU_Z_I = 1'b1; ALU_S_I = 1'b1; ALU_P_I = 1'b0;
        ALU_UPD_I = 1'b1; INR_UPD_I = 1'b1;
        tick();
        ALU_UPD_I = 1'b0; INR_UPD_I = 1'b0;
        mflag[0] = 0; mflag[1] = 1; mflag[2] = 1; mflag[3] = 0;
        checks++;
        if ({C_O, Z_O, S_O, P_O} !== 4'b0110) begin errors++; $display("FAIL load_priority: got %b want 0110", {C_O, Z_O, S_O, P_O}); end
    endtask

    task automatic test_rotate_carry();
        logic b1, v1;
        alu_load(0, 0, 0, 0);
        issue_rot(2, 8'h81, b1, v1);
        checks++;
        if ({b1, v1} !== 2'b10) begin errors++; $display("FAIL ral_k1: got busy/vld %b want 10", {b1, v1}); end
        checks++;
        if ({ACC_VLD_O, BUSY_O, ACC_O, C_O} !== {1'b1, 1'b1, 8'h02, 1'b1}) begin
            errors++; $display("FAIL ral_result: got vld=%b busy=%b acc=%h c=%b want 1 1 02 1", ACC_VLD_O, BUSY_O, ACC_O, C_O);
        end
        tick();
        checks++;
        if ({ACC_VLD_O, BUSY_O} !== 2'b00) begin errors++; $display("FAIL ral_done: got vld/busy %b want 00", {ACC_VLD_O, BUSY_O}); end
        issue_rot(3, 8'h02, b1, v1);
        checks++;
        if ({ACC_VLD_O, ACC_O, C_O} !== {1'b1, 8'h81, 1'b0}) begin
            errors++; $display("FAIL rar_result: got vld=%b acc=%h c=%b want 1 81 0", ACC_VLD_O, ACC_O, C_O);
        end
        tick();
        mflag[0] = 0; macc = 8'h81;
    endtask

    task automatic test_carry_conflict();
        ROT_OP_I = 2'b00; ACC_I = 8'h80; ROT_I = 1'b1;
        tick();
        ROT_I = 1'b0;
        ALU_C_I = 1'b0; ALU_Z_I = 1'b1; ALU_S_I = 1'b0; ALU_P_I = 1'b0; ALU_UPD_I = 1'b1;
        tick();
        ALU_UPD_I = 1'b0; ALU_Z_I = 1'b0;
        checks++;
        if ({ACC_VLD_O, ACC_O} !== {1'b1, 8'h01}) begin errors++; $display("FAIL conflict_acc: got vld=%b acc=%h want 1 01", ACC_VLD_O, ACC_O); end
        checks++;
        if ({C_O, Z_O, S_O, P_O} !== 4'b1100) begin errors++; $display("FAIL conflict_flags: got %b want 1100", {C_O, Z_O, S_O, P_O}); end
        tick();
        mflag[0] = 1; mflag[1] = 1; mflag[2] = 0; mflag[3] = 0; macc = 8'h01;
    endtask

    task automatic test_cond();
        logic b1, v1;
        alu_load(0, 1, 0, 0);
        issue_cond(3'b001, b1, v1);
        checks++;
        if ({b1, v1} !== 2'b10) begin errors++; $display("FAIL cond_k1: got busy/vld %b want 10", {b1, v1}); end
        checks++;
        if ({COND_VLD_O, COND_TRUE_O} !== 2'b10) begin errors++; $display("FAIL cond_z_false: got vld/true %b want 10", {COND_VLD_O, COND_TRUE_O}); end
        tick();
        checks++;
        if ({COND_VLD_O, BUSY_O, COND_TRUE_O} !== 3'b000) begin errors++; $display("FAIL cond_pulse_end: got %b want 000", {COND_VLD_O, BUSY_O, COND_TRUE_O}); end
        issue_cond(3'b101, b1, v1);
        checks++;
        if ({COND_VLD_O, COND_TRUE_O} !== 2'b11) begin errors++; $display("FAIL cond_z_true: got vld/true %b want 11", {COND_VLD_O, COND_TRUE_O}); end
        tick();
        checks++;
        if ({COND_VLD_O, COND_TRUE_O, ACC_O} !== {2'b01, macc}) begin
            errors++; $display("FAIL cond_hold: got vld=%b true=%b acc=%h want 0 1 %h", COND_VLD_O, COND_TRUE_O, ACC_O, macc);
        end
        mtrue = 1'b1;
        // Flag load at the EVAL exit edge must not affect the result.
        COND_I = 3'b101; COND_REQ_I = 1'b1;
        tick();
        COND_REQ_I = 1'b0;
        ALU_C_I = 1'b0; ALU_Z_I = 1'b0; ALU_S_I = 1'b0; ALU_P_I = 1'b0; ALU_UPD_I = 1'b1;
        tick();
        ALU_UPD_I = 1'b0;
        mflag[1] = 0;
        checks++;
        if ({COND_VLD_O, COND_TRUE_O, Z_O} !== 3'b110) begin errors++; $display("FAIL cond_late_load: got vld/true/z %b want 110", {COND_VLD_O, COND_TRUE_O, Z_O}); end
        tick();
    endtask

    task automatic test_collision();
        logic saw_acc, saw_cond;
        int   res, nc;
        model_rot(0, 8'h41, mflag[0], res, nc);
        ROT_OP_I = 2'b00; ACC_I = 8'h41; ROT_I = 1'b1; COND_I = 3'b100; COND_REQ_I = 1'b1;
        tick();
        ROT_I = 1'b0; COND_REQ_I = 1'b0;
        saw_acc = 1'b0; saw_cond = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw_acc |= ACC_VLD_O; saw_cond |= COND_VLD_O;
            tick();
        end
        mflag[0] = nc; macc = res[7:0];
        checks++;
        if ({saw_acc, saw_cond} !== 2'b10) begin errors++; $display("FAIL collision_rot_wins: got acc/cond vld %b want 10", {saw_acc, saw_cond}); end
        checks++;
        if ({ACC_O, C_O, COND_TRUE_O} !== {macc, mflag[0][0], mtrue}) begin
            errors++; $display("FAIL collision_result: got acc=%h c=%b t=%b want %h %0d %b", ACC_O, C_O, COND_TRUE_O, macc, mflag[0], mtrue);
        end
        // Condition requests while busy are dropped, not queued.
        ROT_OP_I = 2'b01; ACC_I = 8'h10; ROT_I = 1'b1;
        tick();
        ROT_I = 1'b0; COND_I = 3'b000; COND_REQ_I = 1'b1;
        tick();
        tick();
        COND_REQ_I = 1'b0;
        saw_cond = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw_cond |= COND_VLD_O | BUSY_O;
            tick();
        end
        model_rot(1, 8'h10, mflag[0], res, nc);
        mflag[0] = nc; macc = res[7:0];
        checks++;
        if (saw_cond !== 1'b0) begin errors++; $display("FAIL busy_req_ignored: got %b want 0", saw_cond); end
    endtask

    task automatic test_random();
        int   kind, op, a, res, nc, fv [4];
        logic is_rot;
        logic [2:0] cnd;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) fv[i] = $urandom_range(0, 1);
            is_rot = $urandom_range(0, 1) == 1;
            op = $urandom_range(0, 3);
            a = $urandom_range(0, 255);
            cnd = 3'($urandom_range(0, 7));
            ALU_C_I = fv[0][0]; ALU_Z_I = fv[1][0]; ALU_S_I = fv[2][0]; ALU_P_I = fv[3][0];
            ALU_UPD_I = (kind == 1 || kind == 3);
            INR_UPD_I = (kind == 2 || kind == 3);
            ROT_I = is_rot; ROT_OP_I = op[1:0]; ACC_I = a[7:0];
            COND_REQ_I = !is_rot; COND_I = cnd;
            tick();
            ALU_UPD_I = 1'b0; INR_UPD_I = 1'b0; ROT_I = 1'b0; COND_REQ_I = 1'b0;
            if (kind == 1 || kind == 3) for (int i = 0; i < 4; i++) mflag[i] = fv[i];
            else if (kind == 2) for (int i = 1; i < 4; i++) mflag[i] = fv[i];
            checks++;
            if (BUSY_O !== 1'b1) begin errors++; $display("FAIL rand_busy[%0d]: got %b want 1", n, BUSY_O); end
            tick();
            if (is_rot) begin
                model_rot(op, a, mflag[0], res, nc);
                mflag[0] = nc; macc = res[7:0];
            end else begin
                mtrue = (mflag[cnd[1:0]] == int'(cnd[2]));
            end
            checks++;
            if ({ACC_VLD_O, COND_VLD_O, ACC_O, COND_TRUE_O, C_O, Z_O, S_O, P_O} !==
                {is_rot, !is_rot, macc, mtrue, mflags()}) begin
                errors++;
                $display("FAIL rand_op[%0d]: got av=%b cv=%b acc=%h t=%b f=%b want %b %b %h %b %b",
                         n, ACC_VLD_O, COND_VLD_O, ACC_O, COND_TRUE_O, {C_O, Z_O, S_O, P_O},
                         is_rot, !is_rot, macc, mtrue, mflags());
            end
            tick();
            checks++;
            if ({ACC_VLD_O, COND_VLD_O, BUSY_O} !== 3'b000) begin errors++; $display("FAIL rand_idle[%0d]: got %b want 000", n, {ACC_VLD_O, COND_VLD_O, BUSY_O}); end
        end
    endtask

    initial begin
        test_reset();
        test_flag_load();
        test_rotate_carry();
        test_carry_conflict();
        test_cond();
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_flag.md
# cpu_flag

Flag register and condition unit for the Intel8008 core. It captures the C/Z/S/P outputs of the ALU, executes the four accumulator rotate instructions (which read and write carry), and evaluates the 8008 jump/call/return condition field against the stored flags. It sits between the ALU and the instruction sequencer, which issues rotate and condition requests with a single-pulse handshake.

## Interface
Parameters: none.

- CLK_I  in  1  clock; all state changes on rising edge
- RST_N_I  in  1  reset, asynchronous, active-low
- ALU_C_I, ALU_Z_I, ALU_S_I, ALU_P_I  in  1 each  flag outputs of the ALU
- ALU_UPD_I  in  1  load all four flags from ALU_*_I
- INR_UPD_I  in  1  load Z, S, P only (INr/DCr); C unchanged
- ROT_I  in  1  rotate request
- ROT_OP_I  in  2  00 RLC, 01 RRC, 10 RAL, 11 RAR
- ACC_I  in  8  accumulator operand for rotate
- COND_REQ_I  in  1  condition evaluation request
- COND_I  in  3  {T, CC[1:0]}; CC 00=C, 01=Z, 10=S, 11=P; T=1 test true, T=0 test false
- ACC_O  out  8  rotate result, registered
- ACC_VLD_O  out  1  one-cycle pulse, ACC_O valid
- COND_TRUE_O  out  1  condition result, registered
- COND_VLD_O  out  1  one-cycle pulse, COND_TRUE_O valid
- C_O, Z_O, S_O, P_O  out  1 each  flag register
- BUSY_O  out  1  high when state is not IDLE

## Operation
- States: IDLE, ROT, EVAL, DONE. BUSY_O = (state != IDLE).
- Flag loads are accepted in every state. ALU_UPD_I has priority over INR_UPD_I when both are high.
- IDLE: if ROT_I = 1, capture ACC_I and ROT_OP_I, then go to ROT. Else if COND_REQ_I = 1, capture COND_I, then go to EVAL.
  - If both requests are high, ROT wins and COND_REQ_I is dropped.
  - Requests arriving while BUSY_O = 1 are ignored, not queued.
- ROT, one cycle. At the exiting edge, ACC_O and C are written as follows (C is the flag-register value during ROT):
  - RLC: ACC_O = {A[6:0],A[7]}, C = A[7]
  - RRC: ACC_O = {A[0],A[7:1]}, C = A[0]
  - RAL: ACC_O = {A[6:0],C}, C = A[7]
  - RAR: ACC_O = {C,A[7:1]}, C = A[0]
  - Then go to DONE.
- Carry conflict at the ROT exit edge: the rotate carry write wins over ALU_UPD_I's carry. Z, S, P from ALU_UPD_I/INR_UPD_I still load.
- EVAL, one cycle. At the exiting edge, COND_TRUE_O = (selected flag == T), using the flag-register values present during the EVAL cycle. Then go to DONE.
- DONE, one cycle. ACC_VLD_O = 1 if entered from ROT; COND_VLD_O = 1 if entered from EVAL. Then go to IDLE.
- ACC_O and COND_TRUE_O hold their values until the next respective operation.
- Flags are stored exactly as supplied by the ALU; no recomputation.

## Timing
- Reset (async assert, release synchronous to CLK_I):
  - state = IDLE
  - C_O = Z_O = S_O = P_O = 0, ACC_O = 0x00, COND_TRUE_O = 0
  - ACC_VLD_O = COND_VLD_O = BUSY_O = 0
- Reset mid-operation aborts the operation: no VLD pulse is generated and no flag write occurs.
- Flag load latency is one edge: ALU_UPD_I high in cycle k means C_O..P_O are updated in cycle k+1.
- Request sampled in IDLE at edge k:
  - BUSY_O is high in cycles k+1 and k+2.
  - The VLD pulse is high in cycle k+2.
  - The next request can be accepted at edge k+3.
  - Throughput is one operation per 3 cycles.
- Rotate carry appears on C_O in cycle k+2, aligned with ACC_VLD_O.
- A flag load at edge k (concurrent with a COND request) is visible to EVAL. A flag load at the EVAL exit edge is not.

## Test plan
- Reset with all inputs 0 → all outputs 0, BUSY_O = 0. Assert RST_N_I low during ROT → no ACC_VLD_O pulse, C_O = 0.
- ALU_UPD_I with C,Z,S,P = 1,0,1,1 → C_O..P_O = 1,0,1,1 next cycle. Then INR_UPD_I with 0,0,0,0 → C_O = 1, Z/S/P = 0.
- C_O = 0, ROT_OP_I = RAL, ACC_I = 0x81 → ACC_VLD_O in cycle k+2, ACC_O = 0x02, C_O = 1. Then RAR with ACC_I = 0x02 → ACC_O = 0x81, C_O = 0.
- RLC with ACC_I = 0x80 while ALU_UPD_I (C = 0, Z = 1) is high at the ROT exit edge → ACC_O = 0x01, C_O = 1, Z_O = 1.
- Z_O = 1, COND_I = 3'b001 → COND_TRUE_O = 0. COND_I = 3'b101 → COND_TRUE_O = 1. Each result is accompanied by a one-cycle COND_VLD_O.
- ROT_I and COND_REQ_I high together in IDLE → only ACC_VLD_O pulses. COND_REQ_I pulsed while BUSY_O = 1 → ignored, no COND_VLD_O.
